// File: rtl/riscv_slave_master.sv
// riscv_slave_master: streams 64-bit words into a registered-read slave
// register file, then on request reads them back in order onto an output
// valid/ready stream. The slave is always refilled starting at address 0.
module riscv_slave_master #(
  parameter int abits       = 4,
  parameter int log2_dbytes = 3,
  parameter int depth       = 16,
  localparam int dbits      = 8 * (2 ** log2_dbytes)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [dbits-1:0] s_data,
  input  logic             drain_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [dbits-1:0] out_data,
  output logic [abits:0]   count,
  output logic             full,
  output logic             busy,
  output logic [abits-1:0] m_address,
  output logic             m_w_enable,
  output logic [dbits-1:0] m_w_data,
  input  logic [dbits-1:0] m_r_data
);

  localparam logic [abits:0] DEPTH_C = (abits + 1)'(depth);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [abits-1:0]   wr_ptr_q, wr_ptr_d;
  logic [abits-1:0]   rd_ptr_q, rd_ptr_d;
  logic [abits:0]     count_q, count_d;
  logic               out_valid_q, out_valid_d;
  logic [dbits-1:0]   out_data_q, out_data_d;

  logic               wr_accept;
  logic               last_word;

  // Slave-side strobes and input handshake; writes only happen while filling.
  always_comb begin
    s_ready    = (state_q == FILL) && (count_q < DEPTH_C);
    wr_accept  = s_valid && s_ready;
    m_w_enable = wr_accept;
    m_address  = (state_q == FILL) ? wr_ptr_q : rd_ptr_q;
    m_w_data   = s_data;
    last_word  = ({1'b0, rd_ptr_q} == (count_q - (abits + 1)'(1)));
  end

  // Next-state logic: fill, then per word a two-cycle read followed by output hold.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      FILL: begin
        if (wr_accept) begin
          wr_ptr_d = wr_ptr_q + abits'(1);
          count_d  = count_q + (abits + 1)'(1);
        end
        // A word accepted alongside the request is part of this drain.
        if (drain_req && ((count_q != '0) || wr_accept)) begin
          state_d  = RD_ADDR;
          rd_ptr_d = '0;
        end
      end
      RD_ADDR: begin
        state_d = RD_DATA;
      end
      RD_DATA: begin
        out_data_d  = m_r_data;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (last_word) begin
            state_d  = FILL;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + abits'(1);
            state_d  = RD_ADDR;
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and output registers; reset abandons any drain in progress.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign full      = (count_q == DEPTH_C);
  assign busy      = (state_q != FILL);

endmodule

// File: tb/tb_riscv_slave_master.sv
// Testbench for riscv_slave_master: bench-side slave register file plus a
// queue-based reference of stored words and drain timing.
module tb_riscv_slave_master;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        nrst;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        drain_req;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  count;
  logic        full;
  logic        busy;
  logic [3:0]  m_address;
  logic        m_w_enable;
  logic [63:0] m_w_data;
  logic [63:0] m_r_data;

  riscv_slave_master dut (
    .clk        (clk),
    .nrst       (nrst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .drain_req  (drain_req),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .full       (full),
    .busy       (busy),
    .m_address  (m_address),
    .m_w_enable (m_w_enable),
    .m_w_data   (m_w_data),
    .m_r_data   (m_r_data)
  );

  always #5 clk = ~clk;

  // Slave register file with one-cycle registered read.
  logic [63:0] mem [16];
  always @(posedge clk) begin
    if (m_w_enable) mem[m_address] <= m_w_data;
    m_r_data <= mem[m_address];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: words stored in order, drain flag, index of word being returned,
  // and cycles remaining until that word must be presented.
  logic [63:0] stored[$];
  logic        draining = 1'b0;
  int          idx = 0;
  int          cd = 0;
  int          drained = 0;

  task automatic step(input logic sv, input logic [63:0] sd, input logic dr, input logic ordy);
    logic exp_rdy, exp_ov, acc;
    int n;
    @(negedge clk);
    s_valid = sv; s_data = sd; drain_req = dr; out_ready = ordy;
    #1;
    n = stored.size();
    exp_rdy = !draining && (n < DEPTH);
    exp_ov  = draining && (cd == 0);
    check_eq("busy", 64'(busy), 64'(draining));
    check_eq("s_ready", 64'(s_ready), 64'(exp_rdy));
    check_eq("out_valid", 64'(out_valid), 64'(exp_ov));
    check_eq("count", 64'(count), 64'(n));
    check_eq("full", 64'(full), 64'(n == DEPTH));
    if (!draining) begin
      check_eq("w_enable", 64'(m_w_enable), 64'(sv && exp_rdy));
      if (sv && exp_rdy) begin
        check_eq("w_addr", 64'(m_address), 64'(n));
        check_eq("w_data", m_w_data, sd);
      end
    end else begin
      check_eq("w_enable_drain", 64'(m_w_enable), 64'd0);
      check_eq("r_addr", 64'(m_address), 64'(idx));
    end
    if (exp_ov) check_eq("out_data", out_data, stored[idx]);
    // effect of the coming rising edge
    if (!draining) begin
      acc = sv && exp_rdy;
      if (acc) stored.push_back(sd);
      if (dr && stored.size() > 0) begin
        draining = 1'b1; idx = 0; cd = 2; drained = 0;
      end
    end else if (cd > 0) begin
      cd--;
    end else if (ordy) begin
      drained++;
      if (idx == stored.size() - 1) begin
        draining = 1'b0;
        stored.delete();
      end else begin
        idx++; cd = 2;
      end
    end
  endtask

  task automatic drain_until_idle(input logic sv, input logic [63:0] sd, input logic rnd_ready);
    int k = 0;
    while (draining && k < 200) begin
      step(sv, sd, 1'b0, rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      k++;
    end
    check_eq("drain_timeout", 64'(draining), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0; s_valid = 1'b0; drain_req = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    stored.delete(); draining = 1'b0; cd = 0; idx = 0;
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_s_ready", 64'(s_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] w17;
    nrst = 1'b0; s_valid = 1'b0; s_data = '0; drain_req = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    #1;
    check_eq("init_out_data", out_data, 64'd0);
    check_eq("init_out_valid", 64'(out_valid), 64'd0);
    check_eq("init_count", 64'(count), 64'd0);
    check_eq("init_busy", 64'(busy), 64'd0);
    check_eq("init_full", 64'(full), 64'd0);

    // three words, drain with consumer always ready
    for (int i = 1; i <= 3; i++) step(1'b1, 64'h1111_0000_0000_0000 + 64'(i), 1'b0, 1'b1);
    step(1'b0, 64'd0, 1'b1, 1'b1);
    drain_until_idle(1'b0, 64'd0, 1'b0);
    check_eq("three_drained", 64'(drained), 64'd3);
    step(1'b0, 64'd0, 1'b0, 1'b1);

    // 17 words offered back to back; 17th waits for the drain
    for (int i = 0; i < 16; i++) step(1'b1, 64'hA000 + 64'(i), 1'b0, 1'b0);
    w17 = 64'hA000_0000_0000_0017;
    repeat (3) step(1'b1, w17, 1'b0, 1'b0);
    step(1'b1, w17, 1'b1, 1'b1);
    drain_until_idle(1'b1, w17, 1'b1);
    check_eq("sixteen_drained", 64'(drained), 64'd16);
    step(1'b1, w17, 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b0, 1'b0);
    check_eq("refill_count", 64'(count), 64'd1);
    step(1'b0, 64'd0, 1'b1, 1'b1);
    drain_until_idle(1'b0, 64'd0, 1'b0);

    // two words, first one stalled for five cycles
    step(1'b1, 64'hBEEF_0001, 1'b0, 1'b0);
    step(1'b1, 64'hBEEF_0002, 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 64'd0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 64'd0, 1'b0, 1'b0);
    drain_until_idle(1'b0, 64'd0, 1'b0);

    // drain request while empty is ignored
    step(1'b0, 64'd0, 1'b1, 1'b1);
    step(1'b0, 64'd0, 1'b0, 1'b1);
    check_eq("empty_drain_busy", 64'(busy), 64'd0);

    // drain request together with the 4th write; second request mid-drain
    for (int i = 1; i <= 3; i++) step(1'b1, 64'hC0DE_0000 + 64'(i), 1'b0, 1'b1);
    step(1'b1, 64'hC0DE_0004, 1'b1, 1'b1);
    step(1'b0, 64'd0, 1'b0, 1'b1);
    step(1'b0, 64'd0, 1'b1, 1'b1);
    drain_until_idle(1'b0, 64'd0, 1'b0);
    check_eq("four_drained", 64'(drained), 64'd4);

    // reset while a word is being presented
    step(1'b1, 64'hD00D_0001, 1'b0, 1'b0);
    step(1'b1, 64'hD00D_0002, 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 64'd0, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 64'hE000_0001, 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b1, 1'b1);
    drain_until_idle(1'b0, 64'd0, 1'b0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    end
    drain_until_idle(1'b0, 64'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_slave_master.md
Name: riscv_slave_master

Overview:
- Initiator for the RISC-V slave register peripheral.
- Accepts a valid/ready stream of 64-bit words and writes them to sequential slave addresses until the slave is full.
- On a drain request, reads every stored word back over the slave's one-cycle registered-read port and emits the words in order on a valid/ready output stream.
- Sits between a producer/consumer datapath and one slave instance; the master-side ports connect directly to the slave's address, w_enable, w_data and r_data.

Parameters:
- abits, 4: slave address width.
- log2_dbytes, 3: data bus is 2**log2_dbytes bytes; dbits = 8*2**log2_dbytes (64 by default).
- depth, 16: number of slave entries used; must satisfy 1 <= depth <= 2**abits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- nrst  in  1  reset, synchronous, active-low.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid & s_ready.
- s_data  in  dbits  input word.
- drain_req  in  1  single-cycle request to read back all stored words.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  dbits  output word (registered).
- count  out  abits+1  number of stored, not-yet-drained words.
- full  out  1  count == depth.
- busy  out  1  high in any drain state.
- m_address  out  abits  slave address.
- m_w_enable  out  1  slave write strobe.
- m_w_data  out  dbits  slave write data.
- m_r_data  in  dbits  slave read data; valid one cycle after the address is presented with m_w_enable=0.

Behaviour:
- Reset (nrst=0 at a rising edge):
  - state=FILL; wr_ptr=0, rd_ptr=0, count=0; out_valid=0; out_data=0.
  - Any drain in progress is abandoned. Slave contents are not cleared.
- State FILL:
  - s_ready = (count < depth).
  - m_w_enable = s_valid & s_ready (combinational); m_address = wr_ptr; m_w_data = s_data.
  - On accept: wr_ptr++, count++ at the edge.
- Full condition: when count==depth, s_ready=0, no write is issued and s_valid is held off without loss.
- drain_req in FILL:
  - If count > 0 after any same-cycle write, go to RD_ADDR with rd_ptr=0.
  - A write accepted in the same cycle as drain_req is included in the drain.
  - If count==0 and no write is accepted that cycle, drain_req is ignored.
  - drain_req outside FILL is ignored.
- State RD_ADDR: m_address=rd_ptr, m_w_enable=0, s_ready=0. Next state is RD_DATA.
- State RD_DATA: m_address=rd_ptr, m_w_enable=0; capture m_r_data into out_data; next state is OUT with out_valid=1.
- State OUT:
  - out_valid=1; out_data is stable until handshake.
  - On out_valid & out_ready:
    - If rd_ptr == count-1: go to FILL with wr_ptr=0, rd_ptr=0, count=0, out_valid=0.
    - Otherwise: rd_ptr++, out_valid=0, go to RD_ADDR.
- busy = (state != FILL); s_ready=0 whenever busy.
- Latency:
  - drain_req at cycle T gives first out_valid at T+3.
  - With out_ready held high, each subsequent word appears 3 cycles after the previous handshake.
- Pointers never wrap past depth-1; a drain always returns to address 0 before refill.
- m_w_enable is never asserted outside FILL.

Test Plan:
- Write 0x1111_0000_0000_0001, ..._0002, ..._0003, then pulse drain_req; hold out_ready=1:
  - Outputs are the three words in order; first out_valid 3 cycles after drain_req.
  - count goes 3 -> 0; busy drops after the third handshake.
- Present 17 words with s_valid continuously high (depth=16):
  - Exactly 16 writes to addresses 0..15; full=1; s_ready=0 while the 17th is pending.
  - After drain, the 17th is accepted at address 0.
- Drain 2 words with out_ready low for 5 cycles on the first word:
  - out_valid stays high and out_data stays stable all 5 cycles; no second read is issued.
- Pulse drain_req with count=0 and s_valid=0:
  - No state change; busy=0; no slave reads.
- Pulse drain_req in the same cycle as accepting a 4th word:
  - The drain returns 4 words.
  - A later drain_req pulse during the drain has no effect.
- Assert nrst=0 for one cycle while in OUT:
  - Next cycle out_valid=0, count=0, busy=0, s_ready=1.
  - A new word is written to address 0.
